// File: rtl/alux_pkg.sv
// rtl/alux_pkg.sv - shared encodings and widths for the alux register bank and its loader
package alux_pkg;

  // Register index width of the alux bank (16 registers)
  localparam int REG_IDX_W = 4;
  localparam int LEN_W     = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [LEN_W-1:0]     reg_len_t;

  // Burst op, driven unchanged onto the bank's endreg input
  typedef enum logic [1:0] {
    OP_BOTH = 2'b00,
    OP_HI   = 2'b01,
    OP_LO   = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  // Loader FSM states
  typedef enum logic [1:0] {
    LD_IDLE = 2'b00,
    LD_LO   = 2'b01,
    LD_HI   = 2'b10,
    LD_WR   = 2'b11
  } ld_state_e;

  // State that starts each register of a burst: low beat first for full/low
  // writes, high beat for high-only writes, straight to the write for swaps.
  function automatic ld_state_e first_state(input op_e op);
    case (op)
      OP_BOTH, OP_LO: first_state = LD_LO;
      OP_HI:          first_state = LD_HI;
      default:        first_state = LD_WR;
    endcase
  endfunction

endpackage

// File: rtl/alux_loader_if.sv
// rtl/alux_loader_if.sv - command, data-beat and bank write-port bundle of the alux loader
interface alux_loader_if;
  import alux_pkg::*;

  // Command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  reg_idx_t    cmd_reg;
  reg_len_t    cmd_len;

  // 32-bit data beat channel
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_data;

  // alux bank write port
  logic        regwen;
  reg_idx_t    selwreg;
  logic [1:0]  endreg;
  logic [63:0] inA;

  // Status
  logic        busy;
  logic        done;
  logic        err;

  // Loader side
  modport master (
    input  cmd_valid, cmd_op, cmd_reg, cmd_len,
    input  d_valid, d_data,
    output cmd_ready, d_ready,
    output regwen, selwreg, endreg, inA,
    output busy, done, err
  );

  // Host / bank side
  modport slave (
    output cmd_valid, cmd_op, cmd_reg, cmd_len,
    output d_valid, d_data,
    input  cmd_ready, d_ready,
    input  regwen, selwreg, endreg, inA,
    input  busy, done, err
  );

endinterface

// File: rtl/alux_ld_timeout.sv
// rtl/alux_ld_timeout.sv - clearable saturating idle counter with reached-limit flag
module alux_ld_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] cnt_q, cnt_d;

  // Clear wins over count; the counter parks at the limit so the flag stays up
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/alux_loader.sv
// rtl/alux_loader.sv - burst write master assembling 32-bit beats into alux register writes
module alux_loader
  import alux_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  alux_loader_if.master bus
);

  ld_state_e   state_q, state_d;
  op_e         op_q, op_d;
  reg_idx_t    cur_q, cur_d;
  reg_len_t    rem_q, rem_d;
  logic [63:0] inA_q, inA_d;
  reg_idx_t    selwreg_q;
  logic        regwen_q;
  logic        err_q, err_d;
  logic        cmd_ready_q;

  logic        in_data;
  logic        hit;
  logic        d_ready_c;
  logic        beat;
  logic        cmd_fire;

  assign in_data   = (state_q == LD_LO) || (state_q == LD_HI);
  // Beats are refused in the cycle the abort is taken so none is half-consumed
  assign d_ready_c = in_data && !hit;
  assign beat      = d_ready_c && bus.d_valid;
  assign cmd_fire  = (state_q == LD_IDLE) && cmd_ready_q && bus.cmd_valid;

  alux_ld_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr_i (beat || (state_d != state_q)),
    .en_i  (in_data),
    .hit_o (hit)
  );

  // Next-state, burst bookkeeping and inA assembly
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    inA_d   = inA_q;
    err_d   = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (cmd_fire) begin
          op_d    = op_e'(bus.cmd_op);
          cur_d   = bus.cmd_reg;
          rem_d   = bus.cmd_len;
          state_d = first_state(op_e'(bus.cmd_op));
          if (op_e'(bus.cmd_op) == OP_SWAP) begin
            inA_d = '0;
          end
        end
      end
      LD_LO: begin
        if (hit) begin
          err_d   = 1'b1;
          state_d = LD_IDLE;
        end else if (beat) begin
          inA_d[31:0] = bus.d_data;
          if (op_q == OP_LO) begin
            inA_d[63:32] = '0;
            state_d      = LD_WR;
          end else begin
            state_d = LD_HI;
          end
        end
      end
      LD_HI: begin
        if (hit) begin
          err_d   = 1'b1;
          state_d = LD_IDLE;
        end else if (beat) begin
          inA_d[63:32] = bus.d_data;
          if (op_q == OP_HI) begin
            inA_d[31:0] = '0;
          end
          state_d = LD_WR;
        end
      end
      LD_WR: begin
        if (rem_q == '0) begin
          state_d = LD_IDLE;
        end else begin
          rem_d   = rem_q - 4'd1;
          cur_d   = cur_q + 4'd1;
          state_d = first_state(op_q);
        end
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs; write-port outputs track the state entered next
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_BOTH;
      cur_q       <= '0;
      rem_q       <= '0;
      inA_q       <= '0;
      selwreg_q   <= '0;
      regwen_q    <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      inA_q       <= inA_d;
      regwen_q    <= (state_d == LD_WR);
      err_q       <= err_d;
      cmd_ready_q <= (state_d == LD_IDLE);
      if (state_d == LD_WR) begin
        selwreg_q <= cur_d;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.d_ready   = d_ready_c;
  assign bus.regwen    = regwen_q;
  assign bus.selwreg   = selwreg_q;
  assign bus.endreg    = op_q;
  assign bus.inA       = inA_q;
  assign bus.busy      = (state_q != LD_IDLE);
  assign bus.done      = (state_q == LD_WR) && (rem_q == '0);
  assign bus.err       = err_q;

endmodule

// File: doc/alux_loader.md
# alux_loader

Write-side master for the `alux` register bank. It takes burst commands plus a 32-bit data stream, assembles 64-bit words, and drives the bank's write port (`regwen`, `selwreg`, `endreg`, `inA`) one register per write cycle, auto-incrementing the register index. It sits between the host/DMA stream and the `alux` data input port, and aborts with an error if the data stream stalls mid-burst.

## Interface
Parameters:
- TIMEOUT, default 255: max idle cycles waiting for a data beat before abort (1..65535).

Ports:
- clock  in  1  master clock, posedge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader accepts a command (registered, high only in IDLE)
- cmd_op  in  2  00 full 64-bit, 10 low word only, 01 high word only, 11 swap words
- cmd_reg  in  4  first register index
- cmd_len  in  4  register count minus 1 (0 means 1 register, 15 means 16)
- d_valid  in  1  data beat present
- d_ready  out  1  loader accepts a data beat
- d_data  in  32  data beat
- regwen  out  1  to alux `regwen`, registered
- selwreg  out  4  to alux `selwreg`, registered
- endreg  out  2  to alux `endreg`, registered, equals `cmd_op` of the active burst
- inA  out  64  to alux `inA`, registered
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse with the last write of a burst
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, LO (wait low beat), HI (wait high beat), WR (issue write).
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&cmd_ready`, latch op, cur=`cmd_reg`, rem=`cmd_len`.
  - Next state: op 00 or 10 → LO; op 01 → HI; op 11 → WR.
- LO:
  - `d_ready`=1.
  - On a beat, latch `inA[31:0]`=`d_data`.
  - Op 00 → HI. Op 10 → WR with `inA[63:32]`=0.
- HI:
  - `d_ready`=1.
  - On a beat, latch `inA[63:32]`=`d_data`.
  - → WR. For op 01, `inA[31:0]`=0.
- Op 11 carries no data. `inA`=0 and the bank performs the swap.
- WR, for exactly one cycle:
  - `regwen`=1, `selwreg`=cur, `endreg`=op.
  - If rem=0: pulse `done` and go to IDLE.
  - Otherwise: rem−1, cur+1 mod 16 (15 wraps to 0), and return to the op's first state (LO, HI or WR).
- Beat order for op 00 is fixed: low word first, then high word.
- Timeout:
  - A counter runs in LO/HI and clears on every accepted beat and on state entry.
  - Reaching TIMEOUT pulses `err`, goes to IDLE, and issues no write for the partial register.
  - Writes already issued stand.
- `busy` = state≠IDLE.
- `regwen`, `done` and `err` are 0 in all cycles other than those stated above.

## Timing
- Reset (`reset`=0) forces, immediately: IDLE, all outputs 0, `cmd_ready`=0.
- `cmd_ready` rises at the first posedge after reset deassertion.
- Reset mid-burst drops the burst with no further writes.
- Cycle numbering is relative to the command handshake edge (c0), beats accepted at the earliest edge:
  - Op 00: low beat c1, high beat c2, `regwen` high during c3.
  - Throughput is 3 cycles per register for op 00, 2 for ops 10/01, 1 for op 11.
  - Op 11 with len=15: 16 consecutive `regwen` cycles c1..c16, `selwreg` cur..cur+15 mod 16.
- `d_ready` is 0 in IDLE and WR.
- Beats presented in those states are held by the source and not consumed.
- `cmd_ready` is 0 during the WR cycle that finishes a burst. The next command is accepted no earlier than the following cycle.
- `done` coincides with the final `regwen` cycle.
- `err` is asserted in the cycle after the counter reaches TIMEOUT. `busy` falls in that same cycle.

## Structure
- Shared package `alux_pkg`:
  - endreg/op encodings: OP_BOTH 2'b00, OP_HI 2'b01, OP_LO 2'b10, OP_SWAP 2'b11.
  - loader state encoding.
  - register-index width (4).
- Sub-module `alux_ld_timeout` holds the clearable up-counter with the compare-to-TIMEOUT flag.
- Everything else (FSM, index/length counters, `inA` assembly) stays in `alux_loader`.

## Test plan
- Full write: cmd op 00, reg 3, len 0, beats 0x11111111 then 0x22222222 → one `regwen` at c3, `selwreg`=3, `endreg`=00, `inA`=0x22222222_11111111, `done` with it.
- Wrap burst: op 10, reg 14, len 3, beats 1,2,3,4 → four writes to regs 14,15,0,1, each with `endreg`=10 and `inA[31:0]`=1..4, upper word 0.
- Swap sweep: op 11, reg 0, len 15 → 16 back-to-back `regwen` cycles, `selwreg` 0..15, `inA`=0, `d_ready` never 1.
- Timeout with TIMEOUT=8: op 00, reg 5, len 1, send only 3 beats → one write to reg 5, then after 8 idle cycles `err` pulses, no write to reg 6, `cmd_ready`=1 next cycle.
- Async reset: assert `reset` low between the low and high beat of op 00 → outputs 0 immediately, no `regwen`. After release, a new op 01 to reg 9 writes `inA`=data<<32.
- Backpressure: `d_valid` toggling every other cycle during op 00, len 1 → correct two writes, no lost or duplicated beats.
